lcd_hd44780_responder: RTL and testbench
========================================

Name: lcd_hd44780_responder

Overview:
- Synthesizable HD44780-compatible character-LCD responder. It is the device end of the 8-bit LCD bus that the team's LCD controllers drive.
- Decodes lcd_rs/lcd_rw/lcd_e/data, executes the instruction set against an 80-byte DDRAM, and models the busy flag and busy-flag/address reads.
- Exposes a 16x2 display readout port. Used as an on-chip LCD stand-in for simulation and bring-up, and as a scoreboard target for controller verification.

Parameters:
- BUSY_CMD, 2000, busy cycles after a standard instruction or data write (40 us at 50 MHz).
- BUSY_CLR, 76500, busy cycles after clear or return home (1.53 ms). Must be at least 80.
- PWR_CYCLES, 500000, power-on busy cycles after reset (10 ms). Must be at least 80.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset. Asynchronous, active-low.
- lcd_rs  in  1  register select (0 = instruction, 1 = data).
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_e  in  1  enable strobe. Asynchronous to clk.
- lcd_data_in  in  8  bus data from host.
- lcd_data_out  out  8  read data to host.
- lcd_data_oe  out  1  drive enable for lcd_data_out.
- disp_row  in  1  readout row.
- disp_col  in  4  readout column, 0-15.
- disp_char  out  8  character at (disp_row, disp_col). 1-cycle latency.
- busy  out  1  busy flag.
- addr_counter  out  7  current address counter (AC).
- display_on, cursor_on, blink_on, inc_mode, two_line  out  1 each  decoded mode flags.
- cmd_dropped  out  1  1-cycle pulse: access rejected because busy.
- addr_error  out  1  1-cycle pulse: Set DDRAM with an invalid address.

Behaviour:
- Reset values:
  - All outputs 0 except inc_mode=1, busy=1.
  - AC=0, two_line=0, DL=1, shift flag S=0, cg_sel=0.
  - FSM enters ST_INIT_FILL.
- Bus synchronisation:
  - lcd_e passes through a 2-flop synchronizer. lcd_rs, lcd_rw and lcd_data_in are delayed through matching stages.
  - Access event = synchronized E falling. rs/rw/data are taken from the stage aligned with the last E-high sample.
  - Host bus requirements: E high at least 3 clk; rs/rw/data stable from E rise to 2 clk after E fall.
  - Effect latency: register update and busy assertion occur within 4 clk of the pin-level E fall.
- FSM states and transitions:
  - ST_INIT_FILL: writes 0x20 to DDRAM idx 0..79, one per cycle, then goes to ST_INIT_WAIT. Busy counter runs from reset.
  - ST_INIT_WAIT: holds busy until PWR_CYCLES have elapsed since reset, then goes to ST_IDLE.
  - ST_IDLE: busy=0. Executes accesses.
  - ST_CLR_FILL: 80-cycle 0x20 fill, then goes to ST_BUSY.
  - ST_BUSY: waits for the countdown to reach 0, then goes to ST_IDLE.
- Busy rules:
  - A write access (rw=0) while busy is ignored and pulses cmd_dropped. AC and DDRAM are unchanged.
  - A data read while busy likewise pulses cmd_dropped.
  - A busy-flag read (rs=0, rw=1) is always serviced.
- Instruction decode, by highest set bit:
  - 0x00: no-op, no busy.
  - 0x01 clear: AC=0, inc_mode=1, go to ST_CLR_FILL, busy BUSY_CLR total.
  - 0x02/0x03 return home: AC=0, busy BUSY_CLR.
  - 0x04-07 entry mode: inc_mode=bit1, S=bit0. S is stored only; display shift is not modelled.
  - 0x08-0F display control: display_on=bit2, cursor_on=bit1, blink_on=bit0.
  - 0x10-1F shift: bit3=0 moves AC by ±1 (bit2=1 right) with wrap; bit3=1 is busy-only.
  - 0x20-3F function set: DL=bit4, two_line=bit3. F is ignored. DL=0 is stored but the bus stays 8-bit.
  - 0x40-7F set CGRAM address: cg_sel=1, busy-only.
  - 0x80-FF set DDRAM address: cg_sel=0.
    - Valid: two_line=1 → 0x00-0x27 or 0x40-0x67; two_line=0 → 0x00-0x4F.
    - Invalid: pulses addr_error, AC unchanged, busy still applied.
  - Every instruction except 0x00 sets busy for BUSY_CMD unless stated otherwise above.
- Data write (rs=1, rw=0):
  - cg_sel=1: data discarded, busy applied.
  - Otherwise: DDRAM[idx(AC)] ← data, then AC steps per inc_mode. Busy BUSY_CMD.
- idx mapping:
  - two_line=1: idx = row*40 + col, where row=AC[6] and col=AC[5:0].
  - two_line=0: idx = AC.
- AC wrap:
  - two_line=1: +1 takes 0x27→0x40 and 0x67→0x00; −1 takes 0x40→0x27 and 0x00→0x67.
  - two_line=0: 0x4F↔0x00.
- Reads:
  - Data read (rs=1, rw=1): lcd_data_out=DDRAM[idx(AC)] while E is high; AC steps on the E fall; busy BUSY_CMD.
  - Busy-flag read (rs=0, rw=1): lcd_data_out={busy, AC}. No AC change.
  - lcd_data_oe = synchronized E & rw. lcd_data_out=0 when oe=0.
- Readout port:
  - disp_char registered, = DDRAM[disp_row*40 + disp_col]. This is valid in both line modes.
  - Returns 0x20 when display_on=0.
- Simultaneous events:
  - An access arriving on the cycle busy drops to 0 is accepted.
  - A readout port read on the same cycle as a DDRAM write returns the old value.
- Reset mid-operation: async reset aborts any fill or countdown, restores reset values, and restarts ST_INIT_FILL. DDRAM is re-cleared by the fill.

Test Plan:
1. PWR_CYCLES=200, rst_n released → busy=1 for 200 clk; all disp_char=0x20; write 0x38 at cycle 50 → cmd_dropped pulse, two_line stays 0.
2. Host init 0x38,0x08,0x01,0x06,0x0C, each waited past busy; then 0x85 and "HELLO WORLD" → row0 cols5-15 read "HELLO WORLD", AC=0x10, display_on=1, cursor_on=0.
3. two_line=1, 0xA7, write 'A','B' → DDRAM 0x27='A', 0x40='B', AC=0x41; with 0x04 set, writing at AC=0x40 → AC=0x27.
4. Command 0x01 then immediate busy-flag read → lcd_data_out=0x80, oe=1 only while E high; after BUSY_CLR read → 0x00; data write during busy → cmd_dropped.
5. two_line=1, 0xB0 → addr_error pulse, AC unchanged; 0x40 then data 0x55 → DDRAM unchanged; 0x80 → cg_sel cleared; next write lands at 0x00.
6. rst_n asserted 40 cycles into ST_CLR_FILL → outputs at reset values at once; after release the fill completes, busy clears after PWR_CYCLES, and DDRAM is all 0x20.

Source files
------------

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible character-LCD responder (device end of the 8-bit LCD bus).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   lcd_rs/lcd_rw/lcd_e/lcd_data_in host bus (lcd_e asynchronous to clk)
//   lcd_data_out, lcd_data_oe      read data and drive enable back to the host
//   disp_row, disp_col, disp_char  16x2 readout port (1-cycle latency)
//   busy, addr_counter, mode flags decoded controller state
//   cmd_dropped, addr_error        1-cycle event pulses
module lcd_hd44780_responder #(
  parameter int unsigned BUSY_CMD   = 2000,
  parameter int unsigned BUSY_CLR   = 76500,
  parameter int unsigned PWR_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic       disp_row,
  input  logic [3:0] disp_col,
  output logic [7:0] disp_char,
  output logic       busy,
  output logic [6:0] addr_counter,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       two_line,
  output logic       cmd_dropped,
  output logic       addr_error
);

  localparam int unsigned DDRAM_N = 80;
  localparam int unsigned AC_W    = 7;
  localparam int unsigned CNT_W   = 32;
  localparam logic [7:0]  SPACE   = 8'h20;

  typedef enum logic [2:0] {
    ST_INIT_FILL,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_CLR_FILL,
    ST_BUSY
  } state_t;

  // Synchronizer stages; index 0 is the first stage, index 2 holds the previous E sample.
  logic [2:0] e_sync_q, rs_sync_q, rw_sync_q;
  logic [7:0] data_s1_q, data_s2_q, data_s3_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AC_W-1:0]   fill_q, fill_d;
  logic [AC_W-1:0]   ac_q, ac_d;
  logic              display_on_q, display_on_d;
  logic              cursor_on_q, cursor_on_d;
  logic              blink_on_q, blink_on_d;
  logic              inc_mode_q, inc_mode_d;
  logic              two_line_q, two_line_d;
  logic              entry_s_q, entry_s_d;
  logic              dl_q, dl_d;
  logic              cg_sel_q, cg_sel_d;
  logic              busy_q, busy_d;
  logic              cmd_dropped_q, cmd_dropped_d;
  logic              addr_error_q, addr_error_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              oe_q, oe_d;
  logic [7:0]        disp_char_q, disp_char_d;

  logic [7:0]        ddram_q [DDRAM_N];
  logic              we_c;
  logic [AC_W-1:0]   waddr_c;
  logic [7:0]        wdata_c;

  logic              ev_c, ev_rs_c, ev_rw_c;
  logic [7:0]        ev_data_c;
  logic              ready_c;
  logic [AC_W-1:0]   cur_idx_c, disp_idx_c;
  logic              cur_ok_c;
  logic [7:0]        cur_char_c;
  logic              unused_mode_c;

  // Next AC value for a +/-1 step, wrapping within the active line layout.
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac, input logic inc,
                                               input logic tl);
    logic [AC_W-1:0] r;
    if (tl) begin
      if (inc) r = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
      else     r = (ac == 7'h40) ? 7'h27 : (ac == 7'h00) ? 7'h67 : ac - 7'd1;
    end else begin
      if (inc) r = (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
      else     r = (ac == 7'h00) ? 7'h4F : ac - 7'd1;
    end
    return r;
  endfunction

  function automatic logic addr_valid(input logic [AC_W-1:0] a, input logic tl);
    if (tl) return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    return a <= 7'h4F;
  endfunction

  // E falls in the synchronized domain; bus fields come from the last E-high stage.
  assign ev_c      = e_sync_q[2] & ~e_sync_q[1];
  assign ev_rs_c   = rs_sync_q[2];
  assign ev_rw_c   = rw_sync_q[2];
  assign ev_data_c = data_s3_q;

  // Accesses are also accepted on the final countdown cycle, as busy drops.
  assign ready_c = (state_q == ST_IDLE) ||
                   (((state_q == ST_BUSY) || (state_q == ST_INIT_WAIT)) && (cnt_q == '0));

  assign cur_idx_c  = two_line_q ? ((ac_q[6] ? 7'd40 : 7'd0) + AC_W'(ac_q[5:0])) : ac_q;
  assign cur_ok_c   = cur_idx_c < AC_W'(DDRAM_N);
  assign cur_char_c = cur_ok_c ? ddram_q[cur_idx_c] : SPACE;
  assign disp_idx_c = (disp_row ? 7'd40 : 7'd0) + AC_W'(disp_col);

  // Entry shift flag and data-length bit are stored but have no modelled effect.
  assign unused_mode_c = entry_s_q ^ dl_q;

  // Bus synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_sync_q  <= '0;
      rs_sync_q <= '0;
      rw_sync_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      data_s3_q <= '0;
    end else begin
      e_sync_q  <= {e_sync_q[1:0], lcd_e};
      rs_sync_q <= {rs_sync_q[1:0], lcd_rs};
      rw_sync_q <= {rw_sync_q[1:0], lcd_rw};
      data_s1_q <= lcd_data_in;
      data_s2_q <= data_s1_q;
      data_s3_q <= data_s2_q;
    end
  end

  // Next-state, fill/countdown and access execution.
  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    fill_d        = fill_q;
    ac_d          = ac_q;
    display_on_d  = display_on_q;
    cursor_on_d   = cursor_on_q;
    blink_on_d    = blink_on_q;
    inc_mode_d    = inc_mode_q;
    two_line_d    = two_line_q;
    entry_s_d     = entry_s_q;
    dl_d          = dl_q;
    cg_sel_d      = cg_sel_q;
    cmd_dropped_d = 1'b0;
    addr_error_d  = 1'b0;
    we_c          = 1'b0;
    waddr_c       = cur_idx_c;
    wdata_c       = ev_data_c;

    case (state_q)
      ST_INIT_FILL, ST_CLR_FILL: begin
        we_c    = 1'b1;
        waddr_c = fill_q;
        wdata_c = SPACE;
        if (fill_q == AC_W'(DDRAM_N - 1)) begin
          fill_d = '0;
          if (cnt_q == '0)                 state_d = ST_IDLE;
          else if (state_q == ST_INIT_FILL) state_d = ST_INIT_WAIT;
          else                             state_d = ST_BUSY;
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      ST_INIT_WAIT, ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (ev_c) begin
      if (ev_rw_c && !ev_rs_c) begin
        // Busy-flag read: serviced while E is high, no side effects.
      end else if (!ready_c) begin
        cmd_dropped_d = 1'b1;
      end else if (ev_rw_c) begin
        ac_d    = ac_step(ac_q, inc_mode_q, two_line_q);
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(BUSY_CMD - 1);
      end else if (ev_rs_c) begin
        if (!cg_sel_q) begin
          we_c = cur_ok_c;
          ac_d = ac_step(ac_q, inc_mode_q, two_line_q);
        end
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(BUSY_CMD - 1);
      end else begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(BUSY_CMD - 1);
        casez (ev_data_c)
          8'b1???????: begin
            cg_sel_d = 1'b0;
            if (addr_valid(ev_data_c[6:0], two_line_q)) ac_d = ev_data_c[6:0];
            else                                        addr_error_d = 1'b1;
          end
          8'b01??????: cg_sel_d = 1'b1;
          8'b001?????: begin
            dl_d       = ev_data_c[4];
            two_line_d = ev_data_c[3];
          end
          8'b0001????: begin
            if (!ev_data_c[3]) ac_d = ac_step(ac_q, ev_data_c[2], two_line_q);
          end
          8'b00001???: begin
            display_on_d = ev_data_c[2];
            cursor_on_d  = ev_data_c[1];
            blink_on_d   = ev_data_c[0];
          end
          8'b000001??: begin
            inc_mode_d = ev_data_c[1];
            entry_s_d  = ev_data_c[0];
          end
          8'b0000001?: begin
            ac_d  = '0;
            cnt_d = CNT_W'(BUSY_CLR - 1);
          end
          8'b00000001: begin
            ac_d       = '0;
            inc_mode_d = 1'b1;
            fill_d     = '0;
            state_d    = ST_CLR_FILL;
            cnt_d      = CNT_W'(BUSY_CLR - 1);
          end
          default: state_d = state_q;
        endcase
        if (ev_data_c == 8'h00) cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
      end
    end

    busy_d      = (state_d != ST_IDLE);
    oe_d        = e_sync_q[0] & rw_sync_q[0];
    data_out_d  = oe_d ? (rs_sync_q[0] ? cur_char_c : {busy_q, ac_q}) : 8'h00;
    disp_char_d = display_on_q ? ddram_q[disp_idx_c] : SPACE;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT_FILL;
      cnt_q         <= CNT_W'(PWR_CYCLES - 1);
      fill_q        <= '0;
      ac_q          <= '0;
      display_on_q  <= 1'b0;
      cursor_on_q   <= 1'b0;
      blink_on_q    <= 1'b0;
      inc_mode_q    <= 1'b1;
      two_line_q    <= 1'b0;
      entry_s_q     <= 1'b0;
      dl_q          <= 1'b1;
      cg_sel_q      <= 1'b0;
      busy_q        <= 1'b1;
      cmd_dropped_q <= 1'b0;
      addr_error_q  <= 1'b0;
      data_out_q    <= '0;
      oe_q          <= 1'b0;
      disp_char_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      ac_q          <= ac_d;
      display_on_q  <= display_on_d;
      cursor_on_q   <= cursor_on_d;
      blink_on_q    <= blink_on_d;
      inc_mode_q    <= inc_mode_d;
      two_line_q    <= two_line_d;
      entry_s_q     <= entry_s_d;
      dl_q          <= dl_d;
      cg_sel_q      <= cg_sel_d;
      busy_q        <= busy_d;
      cmd_dropped_q <= cmd_dropped_d;
      addr_error_q  <= addr_error_d;
      data_out_q    <= data_out_d;
      oe_q          <= oe_d;
      disp_char_q   <= disp_char_d;
    end
  end

  // DDRAM storage; contents are rebuilt by the fill after every reset.
  always_ff @(posedge clk) begin
    if (we_c) ddram_q[waddr_c] <= wdata_c;
  end

  assign lcd_data_out = data_out_q;
  assign lcd_data_oe  = oe_q;
  assign disp_char    = disp_char_q;
  assign busy         = busy_q;
  assign addr_counter = ac_q;
  assign display_on   = display_on_q;
  assign cursor_on    = cursor_on_q;
  assign blink_on     = blink_on_q;
  assign inc_mode     = inc_mode_q;
  assign two_line     = two_line_q;
  assign cmd_dropped  = cmd_dropped_q;
  assign addr_error   = addr_error_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: directed vector table plus
// hand-written sequences for reset, busy timing, clear and mid-fill reset.
module tb_lcd_hd44780_responder;

  localparam int unsigned BUSY_CMD   = 20;
  localparam int unsigned BUSY_CLR   = 150;
  localparam int unsigned PWR_CYCLES = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic       disp_row = 1'b0;
  logic [3:0] disp_col = 4'd0;
  logic [7:0] disp_char;
  logic       busy;
  logic [6:0] addr_counter;
  logic       display_on, cursor_on, blink_on, inc_mode, two_line;
  logic       cmd_dropped, addr_error;

  lcd_hd44780_responder #(
    .BUSY_CMD(BUSY_CMD), .BUSY_CLR(BUSY_CLR), .PWR_CYCLES(PWR_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .disp_row(disp_row), .disp_col(disp_col), .disp_char(disp_char), .busy(busy),
    .addr_counter(addr_counter), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .inc_mode(inc_mode), .two_line(two_line),
    .cmd_dropped(cmd_dropped), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int drop_cnt = 0;
  int aerr_cnt = 0;

  always @(negedge clk) begin
    if (cmd_dropped === 1'b1) drop_cnt++;
    if (addr_error === 1'b1) aerr_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef enum logic [1:0] {OP_INS, OP_WR, OP_RD} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] d;
    logic [6:0] ac;
    logic [4:0] fl;   // {two_line, display_on, cursor_on, blink_on, inc_mode}
    logic [7:0] rd;
    logic       aerr;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bus_access(input logic rs, input logic rw, input logic [7:0] d,
                            output logic [7:0] rd, output logic rd_oe);
    @(negedge clk); lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
    @(negedge clk); lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    rd = lcd_data_out; rd_oe = lcd_data_oe;
    @(negedge clk); lcd_e = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    if (busy !== 1'b0) check("wait_idle timeout", 32'(busy), 32'd0);
  endtask

  // Counts cycles busy stays high after it next rises.
  task automatic measure_busy(output int n);
    int w = 0;
    n = 0;
    while (busy !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
    if (busy !== 1'b1) begin n = -1; return; end
    while (busy === 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic read_disp(input logic r, input logic [3:0] c, output logic [7:0] ch);
    @(negedge clk); disp_row = r; disp_col = c;
    @(negedge clk); ch = disp_char;
  endtask

  function automatic logic [31:0] out_vec();
    return {busy, addr_counter, inc_mode, display_on, cursor_on, blink_on, two_line,
            lcd_data_oe, lcd_data_out, disp_char, cmd_dropped, addr_error};
  endfunction

  function automatic void add(op_t op, logic [7:0] d, logic [6:0] ac, logic [4:0] fl,
                              logic [7:0] rd, logic aerr);
    vq.push_back('{op, d, ac, fl, rd, aerr});
  endfunction

  logic [7:0] rd, ch;
  logic       rd_oe;
  int         n_busy, d0, a0;
  string      hello = "HELLO WORLD";
  logic [7:0] row0_exp [16];

  initial begin
    // Vector table: instruction/data/read, expected AC, flags, read data, addr_error.
    add(OP_INS, 8'h38, 7'h00, 5'b10001, 8'h00, 1'b0);
    add(OP_INS, 8'h08, 7'h00, 5'b10001, 8'h00, 1'b0);
    add(OP_INS, 8'h01, 7'h00, 5'b10001, 8'h00, 1'b0);
    add(OP_INS, 8'h06, 7'h00, 5'b10001, 8'h00, 1'b0);
    add(OP_INS, 8'h0C, 7'h00, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'h85, 7'h05, 5'b11001, 8'h00, 1'b0);
    for (int i = 0; i < 11; i++) add(OP_WR, hello[i], 7'(6 + i), 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'h0F, 7'h10, 5'b11111, 8'h00, 1'b0);
    add(OP_INS, 8'h0C, 7'h10, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'h14, 7'h11, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'h10, 7'h10, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'h18, 7'h10, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'hA7, 7'h27, 5'b11001, 8'h00, 1'b0);
    add(OP_WR,  8'h41, 7'h40, 5'b11001, 8'h00, 1'b0);
    add(OP_WR,  8'h42, 7'h41, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'hA7, 7'h27, 5'b11001, 8'h00, 1'b0);
    add(OP_RD,  8'h00, 7'h40, 5'b11001, 8'h41, 1'b0);
    add(OP_RD,  8'h00, 7'h41, 5'b11001, 8'h42, 1'b0);
    add(OP_INS, 8'h04, 7'h41, 5'b11000, 8'h00, 1'b0);
    add(OP_INS, 8'hC0, 7'h40, 5'b11000, 8'h00, 1'b0);
    add(OP_WR,  8'h43, 7'h27, 5'b11000, 8'h00, 1'b0);
    add(OP_RD,  8'h00, 7'h26, 5'b11000, 8'h41, 1'b0);
    add(OP_INS, 8'h80, 7'h00, 5'b11000, 8'h00, 1'b0);
    add(OP_RD,  8'h00, 7'h67, 5'b11000, 8'h20, 1'b0);
    add(OP_INS, 8'h06, 7'h67, 5'b11001, 8'h00, 1'b0);
    add(OP_WR,  8'h5A, 7'h00, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'hB0, 7'h00, 5'b11001, 8'h00, 1'b1);
    add(OP_INS, 8'h40, 7'h00, 5'b11001, 8'h00, 1'b0);
    add(OP_WR,  8'h55, 7'h00, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'h80, 7'h00, 5'b11001, 8'h00, 1'b0);
    add(OP_RD,  8'h00, 7'h01, 5'b11001, 8'h20, 1'b0);
    add(OP_INS, 8'h80, 7'h00, 5'b11001, 8'h00, 1'b0);
    add(OP_WR,  8'h51, 7'h01, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'hE7, 7'h67, 5'b11001, 8'h00, 1'b0);
    add(OP_INS, 8'hE8, 7'h67, 5'b11001, 8'h00, 1'b1);
    add(OP_INS, 8'h30, 7'h67, 5'b01001, 8'h00, 1'b0);
    add(OP_INS, 8'hCF, 7'h4F, 5'b01001, 8'h00, 1'b0);
    add(OP_WR,  8'h59, 7'h00, 5'b01001, 8'h00, 1'b0);
    add(OP_INS, 8'hD0, 7'h00, 5'b01001, 8'h00, 1'b1);
    add(OP_INS, 8'h00, 7'h00, 5'b01001, 8'h00, 1'b0);
    add(OP_INS, 8'h38, 7'h00, 5'b11001, 8'h00, 1'b0);
    add(OP_RD,  8'h00, 7'h01, 5'b11001, 8'h51, 1'b0);
    add(OP_INS, 8'hE7, 7'h67, 5'b11001, 8'h00, 1'b0);
    add(OP_RD,  8'h00, 7'h00, 5'b11001, 8'h59, 1'b0);

    // Reset state and power-on busy window with a dropped write at cycle 50.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", out_vec(), 32'h8080_0000);
    @(negedge clk); rst_n = 1'b1;
    d0 = drop_cnt;
    fork
      begin
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 1000) begin @(posedge clk); #1; n_busy++; end
      end
      begin
        repeat (50) @(negedge clk);
        bus_access(1'b0, 1'b0, 8'h38, rd, rd_oe);
      end
    join
    check("power-on busy cycles", 32'(n_busy), 32'(PWR_CYCLES));
    check("init write dropped", 32'(drop_cnt - d0), 32'd1);
    check("init two_line", 32'(two_line), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < vq.size(); i++) begin
      d0 = drop_cnt; a0 = aerr_cnt;
      case (vq[i].op)
        OP_INS:  bus_access(1'b0, 1'b0, vq[i].d, rd, rd_oe);
        OP_WR:   bus_access(1'b1, 1'b0, vq[i].d, rd, rd_oe);
        default: bus_access(1'b1, 1'b1, 8'h00, rd, rd_oe);
      endcase
      wait_idle();
      check($sformatf("vec%0d ac", i), 32'(addr_counter), 32'(vq[i].ac));
      check($sformatf("vec%0d flags", i),
            32'({two_line, display_on, cursor_on, blink_on, inc_mode}), 32'(vq[i].fl));
      check($sformatf("vec%0d addr_error", i), 32'(aerr_cnt - a0), 32'(vq[i].aerr));
      check($sformatf("vec%0d cmd_dropped", i), 32'(drop_cnt - d0), 32'd0);
      if (vq[i].op == OP_RD) begin
        check($sformatf("vec%0d read data", i), 32'(rd), 32'(vq[i].rd));
        check($sformatf("vec%0d read oe", i), 32'(rd_oe), 32'd1);
      end
    end

    // Readout port after the table.
    for (int c = 0; c < 16; c++) row0_exp[c] = 8'h20;
    row0_exp[0] = 8'h51;
    for (int c = 0; c < 11; c++) row0_exp[5 + c] = hello[c];
    for (int c = 0; c < 16; c++) begin
      read_disp(1'b0, 4'(c), ch);
      check($sformatf("row0 col%0d", c), 32'(ch), 32'(row0_exp[c]));
    end
    read_disp(1'b1, 4'd0, ch);
    check("row1 col0", 32'(ch), 32'h43);
    read_disp(1'b1, 4'd1, ch);
    check("row1 col1", 32'(ch), 32'h20);

    // Standard busy length on a data write.
    bus_access(1'b0, 1'b0, 8'hC0, rd, rd_oe);
    wait_idle();
    fork
      measure_busy(n_busy);
      bus_access(1'b1, 1'b0, 8'h58, rd, rd_oe);
    join
    check("data write busy cycles", 32'(n_busy), 32'(BUSY_CMD));
    wait_idle();
    read_disp(1'b1, 4'd0, ch);
    check("row1 col0 X", 32'(ch), 32'h58);

    // Clear: busy-flag read during busy, dropped write, clear length.
    d0 = drop_cnt;
    fork
      measure_busy(n_busy);
      begin
        bus_access(1'b0, 1'b0, 8'h01, rd, rd_oe);
        bus_access(1'b0, 1'b1, 8'h00, rd, rd_oe);
        check("bf read busy", 32'(rd), 32'h80);
        check("bf read oe", 32'(rd_oe), 32'd1);
        check("oe low after E", 32'({lcd_data_oe, lcd_data_out}), 32'd0);
        bus_access(1'b1, 1'b0, 8'h77, rd, rd_oe);
      end
    join
    check("clear busy cycles", 32'(n_busy), 32'(BUSY_CLR));
    check("write during clear dropped", 32'(drop_cnt - d0), 32'd1);
    check("ac after dropped write", 32'(addr_counter), 32'd0);
    wait_idle();
    bus_access(1'b0, 1'b1, 8'h00, rd, rd_oe);
    check("bf read idle", 32'(rd), 32'h00);
    read_disp(1'b0, 4'd5, ch);
    check("clear wiped row0 col5", 32'(ch), 32'h20);

    // Reset during the clear fill.
    bus_access(1'b0, 1'b0, 8'hC0, rd, rd_oe);
    wait_idle();
    bus_access(1'b1, 1'b0, 8'h4B, rd, rd_oe);
    wait_idle();
    read_disp(1'b1, 4'd0, ch);
    check("row1 col0 K", 32'(ch), 32'h4B);
    fork
      bus_access(1'b0, 1'b0, 8'h01, rd, rd_oe);
      begin
        int w = 0;
        while (busy !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
      end
    join
    #1 check("mid-fill reset outputs", out_vec(), 32'h8080_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_busy = 0;
    while (busy === 1'b1 && n_busy < 1000) begin @(posedge clk); #1; n_busy++; end
    check("re-init busy cycles", 32'(n_busy), 32'(PWR_CYCLES));
    bus_access(1'b0, 1'b0, 8'h0C, rd, rd_oe);
    wait_idle();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        read_disp(r[0], 4'(c), ch);
        check($sformatf("refill r%0d c%0d", r, c), 32'(ch), 32'h20);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
